jvs_node_table: RTL and testbench

Parametrised JVS node information store. It sits between the JVS host protocol engine and the core/OSD logic. During bus enumeration it captures each node's identification record (address, name string, command/JVS/communication versions) through a streaming write handshake, and serves committed records through a registered random-access read port. It generalises the fixed 8-node × 64-byte node record to arbitrary depth and name length, and adds allocation, commit/abort, overflow and error semantics.

---
 rtl/jvs_node_table.sv | 251 +++++++++++++++++++++++++
 tb/tb_jvs_node_table.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jvs_node_table.sv
// jvs_node_table: per-node identification store for the JVS host engine.
// Records are opened, filled through a streaming write port, then committed
// or aborted. Committed records are served through a registered read port.
// Optional feature: define JVS_NODE_TABLE_LOOKUP_EN to add an address lookup
// port (lk_addr -> lk_hit/lk_idx).
module jvs_node_table #(
  parameter  int MAX_NODES = 8,
  parameter  int NAME_SIZE = 64,
  // Slot index keeps at least one bit so a single-entry table still elaborates
  localparam int ADDR_W    = (MAX_NODES > 1) ? $clog2(MAX_NODES) : 1,
  localparam int NPOS_W    = $clog2(NAME_SIZE)
) (
  input  logic              clk_sys,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              open,
  input  logic [7:0]        open_addr,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [1:0]        wr_field,
  input  logic [7:0]        wr_data,
  input  logic              commit,
  input  logic              abort,
  output logic              err,
  output logic [ADDR_W:0]   node_count,
  output logic              full,
  output logic              busy,
  input  logic [ADDR_W:0]   rd_idx,
  input  logic [NPOS_W:0]   rd_name_pos,
  output logic              rd_valid,
  output logic [7:0]        rd_addr,
  output logic [7:0]        rd_cmd_ver,
  output logic [7:0]        rd_jvs_ver,
  output logic [7:0]        rd_com_ver,
  output logic [7:0]        rd_name_byte,
  output logic [NPOS_W:0]   rd_name_len
`ifdef JVS_NODE_TABLE_LOOKUP_EN
  ,
  input  logic [7:0]        lk_addr,
  output logic              lk_hit,
  output logic [ADDR_W-1:0] lk_idx
`endif
);

  localparam int NAME_DEPTH = MAX_NODES * NAME_SIZE;
  localparam int MEM_AW     = $clog2(NAME_DEPTH);

  localparam logic [ADDR_W:0] MAX_NODES_L = (ADDR_W+1)'(MAX_NODES);
  localparam logic [NPOS_W:0] NAME_SIZE_L = (NPOS_W+1)'(NAME_SIZE);

  typedef enum logic {
    ST_IDLE,
    ST_OPEN
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   slot;
  logic [NPOS_W:0]     cur_len;
  logic [MAX_NODES-1:0] valid;

  // Per-slot record fields; a slot is only visible once its valid bit is set
  logic [7:0]          addr_mem [MAX_NODES];
  logic [7:0]          cmd_mem  [MAX_NODES];
  logic [7:0]          jvs_mem  [MAX_NODES];
  logic [7:0]          com_mem  [MAX_NODES];
  logic [NPOS_W:0]     len_mem  [MAX_NODES];

  // Name bytes, one NAME_SIZE window per slot, single write / single read port
  logic [7:0]          name_mem [NAME_DEPTH];
  logic [7:0]          name_q;
  logic                name_ok;

  logic                open_ok;
  logic                beat;
  logic                name_room;
  logic                name_wr;
  logic [ADDR_W-1:0]   open_slot;
  logic [MEM_AW-1:0]   wr_mem_addr;

  logic [ADDR_W-1:0]   rd_sel;
  logic                rd_hit;
  logic                name_ok_d;
  logic [MEM_AW-1:0]   rd_mem_addr;

  assign full         = (node_count == MAX_NODES_L);
  assign wr_ready     = busy;
  assign open_slot    = node_count[ADDR_W-1:0];
  assign wr_mem_addr  = MEM_AW'(int'(slot) * NAME_SIZE + int'(cur_len));
  assign rd_name_byte = name_ok ? name_q : 8'h00;

  // Qualify the incoming operations; clear masks everything, abort drops the beat
  always_comb begin
    open_ok   = 1'b0;
    beat      = 1'b0;
    name_wr   = 1'b0;
    name_room = (cur_len < NAME_SIZE_L);
    if (!clear) begin
      open_ok = (state == ST_IDLE) && open && !full;
      beat    = (state == ST_OPEN) && wr_valid && !abort;
      name_wr = beat && (wr_field == 2'd0) && name_room;
    end
  end

  // Record lifecycle FSM: allocation, name position, commit/abort and error pulse
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      slot       <= '0;
      cur_len    <= '0;
      valid      <= '0;
      node_count <= '0;
      err        <= 1'b0;
    end else begin
      err <= 1'b0;
      if (clear) begin
        state      <= ST_IDLE;
        busy       <= 1'b0;
        valid      <= '0;
        node_count <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (open_ok) begin
              state   <= ST_OPEN;
              busy    <= 1'b1;
              slot    <= open_slot;
              cur_len <= '0;
            end
            if ((open && full) || commit || abort) begin
              err <= 1'b1;
            end
          end
          ST_OPEN: begin
            if (open) begin
              err <= 1'b1;
            end
            if (beat && (wr_field == 2'd0)) begin
              if (name_room) begin
                cur_len <= cur_len + (NPOS_W+1)'(1);
              end else begin
                err <= 1'b1;
              end
            end
            if (abort) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else if (commit) begin
              valid[slot] <= 1'b1;
              node_count  <= node_count + (ADDR_W+1)'(1);
              state       <= ST_IDLE;
              busy        <= 1'b0;
            end
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Record fields: opening a slot zeroes it, accepted beats fill it in
  always_ff @(posedge clk_sys) begin
    if (open_ok) begin
      addr_mem[open_slot] <= open_addr;
      cmd_mem[open_slot]  <= '0;
      jvs_mem[open_slot]  <= '0;
      com_mem[open_slot]  <= '0;
      len_mem[open_slot]  <= '0;
    end else if (beat) begin
      case (wr_field)
        2'd0: if (name_room) len_mem[slot] <= cur_len + (NPOS_W+1)'(1);
        2'd1: cmd_mem[slot] <= wr_data;
        2'd2: jvs_mem[slot] <= wr_data;
        2'd3: com_mem[slot] <= wr_data;
        default: ;
      endcase
    end
  end

  // Decode the read request against the current table contents
  always_comb begin
    rd_sel      = rd_idx[ADDR_W-1:0];
    rd_hit      = (rd_idx < MAX_NODES_L) && valid[rd_sel];
    name_ok_d   = rd_hit && (rd_name_pos < len_mem[rd_sel]);
    rd_mem_addr = '0;
    if (name_ok_d) begin
      rd_mem_addr = MEM_AW'(int'(rd_sel) * NAME_SIZE + int'(rd_name_pos));
    end
  end

  // Name RAM: plain write port plus registered read, no reset so it maps to RAM
  always_ff @(posedge clk_sys) begin
    if (name_wr) begin
      name_mem[wr_mem_addr] <= wr_data;
    end
    name_q <= name_mem[rd_mem_addr];
  end

  // Registered read port: every field is forced to zero for invalid entries
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid    <= 1'b0;
      rd_addr     <= '0;
      rd_cmd_ver  <= '0;
      rd_jvs_ver  <= '0;
      rd_com_ver  <= '0;
      rd_name_len <= '0;
      name_ok     <= 1'b0;
    end else begin
      rd_valid    <= rd_hit;
      rd_addr     <= rd_hit ? addr_mem[rd_sel] : 8'h00;
      rd_cmd_ver  <= rd_hit ? cmd_mem[rd_sel]  : 8'h00;
      rd_jvs_ver  <= rd_hit ? jvs_mem[rd_sel]  : 8'h00;
      rd_com_ver  <= rd_hit ? com_mem[rd_sel]  : 8'h00;
      rd_name_len <= rd_hit ? len_mem[rd_sel]  : '0;
      name_ok     <= name_ok_d;
    end
  end

`ifdef JVS_NODE_TABLE_LOOKUP_EN
  logic              lk_hit_d;
  logic [ADDR_W-1:0] lk_idx_d;

  // Priority search scanning downward so the lowest matching index wins
  always_comb begin
    lk_hit_d = 1'b0;
    lk_idx_d = '0;
    for (int i = MAX_NODES - 1; i >= 0; i--) begin
      if (valid[i] && (addr_mem[i] == lk_addr)) begin
        lk_hit_d = 1'b1;
        lk_idx_d = ADDR_W'(i);
      end
    end
  end

  // Register the lookup result for a one-cycle latency
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      lk_hit <= 1'b0;
      lk_idx <= '0;
    end else begin
      lk_hit <= lk_hit_d;
      lk_idx <= lk_idx_d;
    end
  end
`endif

endmodule

// File: tb/tb_jvs_node_table.sv
// tb_jvs_node_table: directed bench for jvs_node_table with a record-level
// reference model compared against the DUT every cycle, plus literal checks.
// Define JVS_NODE_TABLE_LOOKUP_EN to also exercise the lookup port.
`timescale 1ns/1ps
module tb_jvs_node_table;

  localparam int MAXN = 8;
  localparam int NSZ  = 64;
  localparam int AW   = 3;
  localparam int PW   = 6;

  logic          clk_sys     = 1'b0;
  logic          rst_n       = 1'b1;
  logic          clear       = 1'b0;
  logic          open        = 1'b0;
  logic [7:0]    open_addr   = '0;
  logic          wr_valid    = 1'b0;
  logic          wr_ready;
  logic [1:0]    wr_field    = '0;
  logic [7:0]    wr_data     = '0;
  logic          commit      = 1'b0;
  logic          abort       = 1'b0;
  logic          err;
  logic [AW:0]   node_count;
  logic          full;
  logic          busy;
  logic [AW:0]   rd_idx      = '0;
  logic [PW:0]   rd_name_pos = '0;
  logic          rd_valid;
  logic [7:0]    rd_addr, rd_cmd_ver, rd_jvs_ver, rd_com_ver, rd_name_byte;
  logic [PW:0]   rd_name_len;
`ifdef JVS_NODE_TABLE_LOOKUP_EN
  logic [7:0]    lk_addr     = '0;
  logic          lk_hit;
  logic [AW-1:0] lk_idx;
`endif

  int checks   = 0;
  int failures = 0;
  int err_seen = 0;
  bit chk_on   = 1'b0;

  jvs_node_table #(.MAX_NODES(MAXN), .NAME_SIZE(NSZ)) dut (
    .clk_sys      (clk_sys),
    .rst_n        (rst_n),
    .clear        (clear),
    .open         (open),
    .open_addr    (open_addr),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_field     (wr_field),
    .wr_data      (wr_data),
    .commit       (commit),
    .abort        (abort),
    .err          (err),
    .node_count   (node_count),
    .full         (full),
    .busy         (busy),
    .rd_idx       (rd_idx),
    .rd_name_pos  (rd_name_pos),
    .rd_valid     (rd_valid),
    .rd_addr      (rd_addr),
    .rd_cmd_ver   (rd_cmd_ver),
    .rd_jvs_ver   (rd_jvs_ver),
    .rd_com_ver   (rd_com_ver),
    .rd_name_byte (rd_name_byte),
    .rd_name_len  (rd_name_len)
`ifdef JVS_NODE_TABLE_LOOKUP_EN
    ,
    .lk_addr      (lk_addr),
    .lk_hit       (lk_hit),
    .lk_idx       (lk_idx)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  // Reference model: a table of records plus an "open record" cursor
  bit         m_open;
  int         m_slot;
  int         m_count;
  bit         m_valid [MAXN];
  logic [7:0] m_addr  [MAXN];
  logic [7:0] m_cmd   [MAXN];
  logic [7:0] m_jvs   [MAXN];
  logic [7:0] m_com   [MAXN];
  int         m_len   [MAXN];
  logic [7:0] m_name  [MAXN][NSZ];
  logic       e_err, e_rd_valid, e_lk_hit;
  logic [7:0] e_rd_addr, e_rd_cmd, e_rd_jvs, e_rd_com, e_rd_byte;
  int         e_rd_len, e_lk_idx;
  int         ri, rp;

  // Model update: reads see the table as it was before this edge
  always @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      m_open = 1'b0; m_slot = 0; m_count = 0;
      for (int i = 0; i < MAXN; i++) m_valid[i] = 1'b0;
      e_err = 1'b0; e_rd_valid = 1'b0; e_rd_addr = '0; e_rd_cmd = '0;
      e_rd_jvs = '0; e_rd_com = '0; e_rd_byte = '0; e_rd_len = 0;
      e_lk_hit = 1'b0; e_lk_idx = 0;
    end else begin
      ri = int'(rd_idx);
      rp = int'(rd_name_pos);
      if (ri < MAXN && m_valid[ri]) begin
        e_rd_valid = 1'b1; e_rd_addr = m_addr[ri]; e_rd_cmd = m_cmd[ri];
        e_rd_jvs = m_jvs[ri]; e_rd_com = m_com[ri]; e_rd_len = m_len[ri];
        e_rd_byte = (rp < m_len[ri]) ? m_name[ri][rp] : 8'h00;
      end else begin
        e_rd_valid = 1'b0; e_rd_addr = '0; e_rd_cmd = '0; e_rd_jvs = '0;
        e_rd_com = '0; e_rd_len = 0; e_rd_byte = '0;
      end
`ifdef JVS_NODE_TABLE_LOOKUP_EN
      e_lk_hit = 1'b0; e_lk_idx = 0;
      for (int i = 0; i < MAXN; i++)
        if (!e_lk_hit && m_valid[i] && m_addr[i] == lk_addr) begin
          e_lk_hit = 1'b1; e_lk_idx = i;
        end
`endif
      e_err = 1'b0;
      if (clear) begin
        m_open = 1'b0; m_count = 0;
        for (int i = 0; i < MAXN; i++) m_valid[i] = 1'b0;
      end else if (!m_open) begin
        if (open) begin
          if (m_count == MAXN) e_err = 1'b1;
          else begin
            m_open = 1'b1; m_slot = m_count; m_addr[m_slot] = open_addr;
            m_cmd[m_slot] = '0; m_jvs[m_slot] = '0; m_com[m_slot] = '0; m_len[m_slot] = 0;
          end
        end
        if (commit || abort) e_err = 1'b1;
      end else begin
        if (open) e_err = 1'b1;
        if (wr_valid && !abort) begin
          case (wr_field)
            2'd0: if (m_len[m_slot] == NSZ) e_err = 1'b1;
                  else begin
                    m_name[m_slot][m_len[m_slot]] = wr_data;
                    m_len[m_slot]++;
                  end
            2'd1: m_cmd[m_slot] = wr_data;
            2'd2: m_jvs[m_slot] = wr_data;
            default: m_com[m_slot] = wr_data;
          endcase
        end
        if (abort) m_open = 1'b0;
        else if (commit) begin
          m_valid[m_slot] = 1'b1; m_count++; m_open = 1'b0;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every DUT output against the model on the falling edge
  always @(negedge clk_sys) begin
    if (chk_on) begin
      checkOutput("err",          32'(err),          32'(e_err));
      checkOutput("node_count",   32'(node_count),   32'(m_count));
      checkOutput("full",         32'(full),         32'(m_count == MAXN));
      checkOutput("busy",         32'(busy),         32'(m_open));
      checkOutput("wr_ready",     32'(wr_ready),     32'(m_open));
      checkOutput("rd_valid",     32'(rd_valid),     32'(e_rd_valid));
      checkOutput("rd_addr",      32'(rd_addr),      32'(e_rd_addr));
      checkOutput("rd_cmd_ver",   32'(rd_cmd_ver),   32'(e_rd_cmd));
      checkOutput("rd_jvs_ver",   32'(rd_jvs_ver),   32'(e_rd_jvs));
      checkOutput("rd_com_ver",   32'(rd_com_ver),   32'(e_rd_com));
      checkOutput("rd_name_byte", 32'(rd_name_byte), 32'(e_rd_byte));
      checkOutput("rd_name_len",  32'(rd_name_len),  32'(e_rd_len));
`ifdef JVS_NODE_TABLE_LOOKUP_EN
      checkOutput("lk_hit",       32'(lk_hit),       32'(e_lk_hit));
      checkOutput("lk_idx",       32'(lk_idx),       32'(e_lk_idx));
`endif
    end
  end

  // Count error pulses for the literal pulse-count checks
  always @(negedge clk_sys) begin
    if (err === 1'b1) err_seen++;
  end

  task automatic applyStimulus(input bit op, input logic [7:0] oa, input bit wv,
                               input logic [1:0] wf, input logic [7:0] wd,
                               input bit cm, input bit ab, input bit cl);
    open = op; open_addr = oa; wr_valid = wv; wr_field = wf; wr_data = wd;
    commit = cm; abort = ab; clear = cl;
    @(negedge clk_sys);
    open = 1'b0; wr_valid = 1'b0; commit = 1'b0; abort = 1'b0; clear = 1'b0;
  endtask

  task automatic doOpen(input logic [7:0] a);   applyStimulus(1, a, 0, 0, 0, 0, 0, 0); endtask
  task automatic doWrite(input logic [1:0] f, input logic [7:0] d); applyStimulus(0, 0, 1, f, d, 0, 0, 0); endtask
  task automatic doCommit();                    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0); endtask
  task automatic doAbort();                     applyStimulus(0, 0, 0, 0, 0, 0, 1, 0); endtask
  task automatic doClear();                     applyStimulus(0, 0, 0, 0, 0, 0, 0, 1); endtask
  task automatic idleCycles(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  logic [7:0] namco [6] = '{8'h4E, 8'h41, 8'h4D, 8'h43, 8'h4F, 8'h00};

  // Directed scenario sequence
  initial begin
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk_sys);
    chk_on = 1'b1;
    checkOutput("reset_count",    32'(node_count), 32'd0);
    checkOutput("reset_busy",     32'(busy),       32'd0);
    checkOutput("reset_wr_ready", 32'(wr_ready),   32'd0);
    checkOutput("reset_err",      32'(err),        32'd0);
    checkOutput("reset_rd_valid", 32'(rd_valid),   32'd0);
    rst_n = 1'b1;
    idleCycles(1);

    $display("[TB] first record NAMCO");
    doOpen(8'h01);
    checkOutput("open_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 6; i++) doWrite(2'd0, namco[i]);
    doWrite(2'd1, 8'h13);
    doWrite(2'd2, 8'h30);
    doWrite(2'd3, 8'h10);
    doCommit();
    checkOutput("a_count", 32'(node_count), 32'd1);
    rd_idx = '0; rd_name_pos = '0;
    idleCycles(2);
    checkOutput("a_rd_valid", 32'(rd_valid),     32'd1);
    checkOutput("a_rd_addr",  32'(rd_addr),      32'h01);
    checkOutput("a_name_len", 32'(rd_name_len),  32'd6);
    checkOutput("a_byte0",    32'(rd_name_byte), 32'h4E);
    checkOutput("a_cmd",      32'(rd_cmd_ver),   32'h13);
    checkOutput("a_jvs",      32'(rd_jvs_ver),   32'h30);
    checkOutput("a_com",      32'(rd_com_ver),   32'h10);
    rd_name_pos = 7'd4;
    idleCycles(2);
    checkOutput("a_byte4", 32'(rd_name_byte), 32'h4F);

    $display("[TB] name overflow");
    err_seen = 0;
    doOpen(8'h02);
    for (int i = 0; i < 70; i++) doWrite(2'd0, 8'(i));
    idleCycles(1);
    checkOutput("b_err_pulses", 32'(err_seen), 32'd6);
    doCommit();
    rd_idx = 4'd1; rd_name_pos = 7'd64;
    idleCycles(2);
    checkOutput("b_name_len", 32'(rd_name_len),  32'd64);
    checkOutput("b_pos64",    32'(rd_name_byte), 32'h00);
    rd_name_pos = 7'd63;
    idleCycles(2);
    checkOutput("b_pos63",    32'(rd_name_byte), 32'h3F);
    rd_name_pos = 7'd127;
    idleCycles(2);

    $display("[TB] abort and slot reuse");
    doOpen(8'h03);
    doWrite(2'd0, 8'h41);
    applyStimulus(0, 0, 1, 2'd0, 8'h43, 0, 1, 0);
    doOpen(8'h33);
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 0);
    rd_idx = 4'd2; rd_name_pos = '0;
    idleCycles(2);
    checkOutput("c_count",    32'(node_count), 32'd2);
    checkOutput("c_rd_valid", 32'(rd_valid),   32'd0);
    doOpen(8'h04);
    doWrite(2'd0, 8'h58);
    applyStimulus(0, 0, 1, 2'd1, 8'h55, 1, 0, 0);
    idleCycles(2);
    checkOutput("c_reuse_addr", 32'(rd_addr),    32'h04);
    checkOutput("c_reuse_cmd",  32'(rd_cmd_ver), 32'h55);

    $display("[TB] illegal operations");
    err_seen = 0;
    doWrite(2'd0, 8'h77);
    doCommit();
    doAbort();
    doOpen(8'h05);
    doOpen(8'h06);
    idleCycles(1);
    checkOutput("d_err_pulses", 32'(err_seen), 32'd3);
    doCommit();
    rd_idx = 4'd3;
    idleCycles(2);
    checkOutput("d_addr", 32'(rd_addr), 32'h05);

    $display("[TB] fill table");
    for (int a = 6; a < 10; a++) begin
      doOpen(8'(a));
      doWrite(2'd0, 8'(8'h60 + a));
      doCommit();
    end
    checkOutput("e_full",  32'(full),       32'd1);
    checkOutput("e_count", 32'(node_count), 32'd8);
    err_seen = 0;
    doOpen(8'h0A);
    idleCycles(1);
    checkOutput("e_err_pulses", 32'(err_seen), 32'd1);
    checkOutput("e_busy",       32'(busy),     32'd0);
    for (int i = 0; i < 16; i++) begin
      rd_idx = 4'(i);
      idleCycles(1);
    end
    rd_idx = 4'd8;
    idleCycles(2);
    checkOutput("e_oor_valid", 32'(rd_valid), 32'd0);
    checkOutput("e_oor_addr",  32'(rd_addr),  32'd0);

    $display("[TB] clear with commit");
    doClear();
    checkOutput("f_count_clr", 32'(node_count), 32'd0);
    doOpen(8'h0C);
    doWrite(2'd0, 8'h63);
    doCommit();
    doOpen(8'h0B);
    doWrite(2'd0, 8'h62);
    err_seen = 0;
    applyStimulus(0, 0, 1, 2'd0, 8'h5A, 1, 0, 1);
    idleCycles(2);
    checkOutput("f_count",  32'(node_count), 32'd0);
    checkOutput("f_no_err", 32'(err_seen),   32'd0);
    for (int i = 0; i < MAXN; i++) begin
      rd_idx = 4'(i);
      idleCycles(1);
    end

    $display("[TB] async reset mid-record");
    doOpen(8'h0E);
    doCommit();
    rd_idx = '0; rd_name_pos = '0;
    doOpen(8'h0D);
    doWrite(2'd0, 8'h01);
    doWrite(2'd0, 8'h02);
    checkOutput("g_pre_valid", 32'(rd_valid), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("g_busy",     32'(busy),       32'd0);
    checkOutput("g_wr_ready", 32'(wr_ready),   32'd0);
    checkOutput("g_count",    32'(node_count), 32'd0);
    checkOutput("g_rd_valid", 32'(rd_valid),   32'd0);
    checkOutput("g_rd_addr",  32'(rd_addr),    32'd0);
    @(negedge clk_sys);
    rst_n = 1'b1;
    idleCycles(1);

    $display("[TB] lookup records");
    doOpen(8'h01); doCommit();
    doOpen(8'h02); doCommit();
    doOpen(8'h02); doCommit();
`ifdef JVS_NODE_TABLE_LOOKUP_EN
    lk_addr = 8'h02;
    idleCycles(2);
    checkOutput("h_hit_02", 32'(lk_hit), 32'd1);
    checkOutput("h_idx_02", 32'(lk_idx), 32'd1);
    lk_addr = 8'h05;
    idleCycles(2);
    checkOutput("h_hit_05", 32'(lk_hit), 32'd0);
    checkOutput("h_idx_05", 32'(lk_idx), 32'd0);
    lk_addr = 8'h01;
    idleCycles(2);
    checkOutput("h_idx_01", 32'(lk_idx), 32'd0);
`endif
    idleCycles(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Run-time bound so the bench always terminates
  initial begin
    #200000;
    failures++;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
